// File: rtl/im_stage.sv
// -----------------------------------------------------------------------------
// im_stage : RV32I memory-access stage (execute -> writeback)
//
// Purpose
//   Issues loads/stores to the data-memory port with byte/half/word lane
//   handling, extracts and sign/zero-extends load data, stalls upstream while
//   memory is busy, and registers results into the MEM->WB pipeline register.
//
// Ports
//   i_clk, i_rstn            clock (rising edge), async active-low reset
//   i_im_*                   instruction/control inputs from execute
//   o_dm_req/we/addr/wdata/be, i_dm_rdata/i_dm_ready
//                            data-memory request/response port
//   o_stall                  freeze PC/IF/ID/IE while an access is waiting
//   o_m_alu_out/dst/rf_we    combinational forwarding / hazard outputs
//   o_misaligned             registered one-cycle pulse on illegal access
//   o_iwb_*                  MEM->WB pipeline register outputs
//
// FSM states
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no access outstanding; a legal access is issued from inputs
//   S_WAIT  | access issued, memory not ready; bus held from hold regs
// -----------------------------------------------------------------------------
module im_stage #(
    parameter int WIDTH       = 32,
    parameter int I_ADD_SIZE  = 32,
    parameter int RF_ADD_SIZE = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [WIDTH-1:0]       i_im_alu_out,
    input  logic [WIDTH-1:0]       i_im_write_data,
    input  logic                   i_im_mem_we,
    input  logic                   i_im_mem_re,
    input  logic [2:0]             i_im_mem_size,
    input  logic                   i_im_rf_we_ctrl,
    input  logic [2:0]             i_im_rf_wb_src_ctrl,
    input  logic [WIDTH-1:0]       i_im_sx_data,
    input  logic [I_ADD_SIZE-1:0]  i_im_pc_plus_4,
    input  logic [WIDTH-1:0]       i_im_bu_next_dest_jb,
    input  logic [RF_ADD_SIZE-1:0] i_im_dst,
    output logic                   o_dm_req,
    output logic                   o_dm_we,
    output logic [WIDTH-1:0]       o_dm_addr,
    output logic [WIDTH-1:0]       o_dm_wdata,
    output logic [3:0]             o_dm_be,
    input  logic [WIDTH-1:0]       i_dm_rdata,
    input  logic                   i_dm_ready,
    output logic                   o_stall,
    output logic [WIDTH-1:0]       o_m_alu_out,
    output logic [RF_ADD_SIZE-1:0] o_m_dst,
    output logic                   o_m_rf_we,
    output logic                   o_misaligned,
    output logic [WIDTH-1:0]       o_iwb_load_data,
    output logic [WIDTH-1:0]       o_iwb_alu_out,
    output logic                   o_iwb_rf_we_ctrl,
    output logic [2:0]             o_iwb_rf_wb_src_ctrl,
    output logic [WIDTH-1:0]       o_iwb_sx_data,
    output logic [I_ADD_SIZE-1:0]  o_iwb_pc_plus_4,
    output logic [WIDTH-1:0]       o_iwb_bu_next_dest_jb,
    output logic [RF_ADD_SIZE-1:0] o_iwb_dst
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state, state_nxt;

    // ---------------------------------------------------------------------
    // Access decode
    // ---------------------------------------------------------------------
    logic       access;
    logic [1:0] a;
    logic       size_ok;
    logic       align_ok;
    logic       legal;
    logic       issue;
    logic       illegal;

    assign access  = i_im_mem_we | i_im_mem_re;
    assign a       = i_im_alu_out[1:0];

    always_comb begin
        size_ok = 1'b0;
        if (i_im_mem_we) begin
            case (i_im_mem_size)
                3'b000, 3'b001, 3'b010: size_ok = 1'b1;
                default:                size_ok = 1'b0;
            endcase
        end else if (i_im_mem_re) begin
            case (i_im_mem_size)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_ok = 1'b1;
                default:                                size_ok = 1'b0;
            endcase
        end
    end

    // size[1:0] = 01 is a halfword and 10 a word for every legal code
    assign align_ok = ~((i_im_mem_size[1:0] == 2'b01) & a[0]) &
                      ~((i_im_mem_size[1:0] == 2'b10) & (|a));
    assign legal    = size_ok & align_ok & ~(i_im_mem_we & i_im_mem_re);
    assign issue    = access & legal;
    assign illegal  = access & ~legal;

    // ---------------------------------------------------------------------
    // Lane formatting of the current request
    // ---------------------------------------------------------------------
    logic [3:0]       be_c;
    logic [WIDTH-1:0] wdata_c;

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = i_im_write_data;
        case (i_im_mem_size[1:0])
            2'b00: begin
                be_c    = 4'b0001 << a;
                wdata_c = {4{i_im_write_data[7:0]}};
            end
            2'b01: begin
                be_c    = a[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{i_im_write_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = i_im_write_data;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Request hold registers: captured when an access enters WAIT so the bus
    // stays stable regardless of what upstream does with its inputs.
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] hold_addr;
    logic [WIDTH-1:0] hold_wdata;
    logic [3:0]       hold_be;
    logic             hold_we;
    logic [2:0]       hold_size;
    logic [1:0]       hold_off;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_be    <= '0;
            hold_we    <= 1'b0;
            hold_size  <= '0;
            hold_off   <= '0;
        end else if ((state == S_IDLE) && issue && !i_dm_ready) begin
            hold_addr  <= {i_im_alu_out[WIDTH-1:2], 2'b00};
            hold_wdata <= wdata_c;
            hold_be    <= be_c;
            hold_we    <= i_im_mem_we;
            hold_size  <= i_im_mem_size;
            hold_off   <= a;
        end
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    logic req_raw;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_raw   = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    req_raw = 1'b1;
                    if (!i_dm_ready) begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                req_raw = 1'b1;
                if (i_dm_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request is gated by reset so it drops the moment reset asserts, even
    // though the decode above is purely combinational from the inputs.
    assign o_dm_req = req_raw & i_rstn;
    assign o_stall  = o_dm_req & ~i_dm_ready;

    // Bus fields are zeroed when no request is active to keep the port quiet.
    always_comb begin
        o_dm_addr  = '0;
        o_dm_wdata = '0;
        o_dm_be    = '0;
        o_dm_we    = 1'b0;
        if (o_dm_req) begin
            if (state == S_WAIT) begin
                o_dm_addr  = hold_addr;
                o_dm_wdata = hold_wdata;
                o_dm_be    = hold_be;
                o_dm_we    = hold_we;
            end else begin
                o_dm_addr  = {i_im_alu_out[WIDTH-1:2], 2'b00};
                o_dm_wdata = wdata_c;
                o_dm_be    = be_c;
                o_dm_we    = i_im_mem_we;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Load extraction
    // ---------------------------------------------------------------------
    logic [2:0]       ld_size;
    logic [1:0]       ld_off;
    logic             ld_active;
    logic [WIDTH-1:0] lane;
    logic [WIDTH-1:0] load_data;

    assign ld_size   = (state == S_WAIT) ? hold_size : i_im_mem_size;
    assign ld_off    = (state == S_WAIT) ? hold_off  : a;
    assign ld_active = o_dm_req & ~o_dm_we;
    assign lane      = i_dm_rdata >> {ld_off, 3'b000};

    always_comb begin
        load_data = '0;
        if (ld_active) begin
            case (ld_size)
                3'b000:  load_data = {{(WIDTH-8){lane[7]}}, lane[7:0]};
                3'b001:  load_data = {{(WIDTH-16){lane[15]}}, lane[15:0]};
                3'b100:  load_data = {{(WIDTH-8){1'b0}}, lane[7:0]};
                3'b101:  load_data = {{(WIDTH-16){1'b0}}, lane[15:0]};
                default: load_data = i_dm_rdata;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Forwarding / hazard outputs
    // ---------------------------------------------------------------------
    assign o_m_alu_out = i_im_alu_out;
    assign o_m_dst     = i_im_dst;
    assign o_m_rf_we   = i_im_rf_we_ctrl;

    // ---------------------------------------------------------------------
    // MEM->WB pipeline register
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_misaligned          <= 1'b0;
            o_iwb_load_data       <= '0;
            o_iwb_alu_out         <= '0;
            o_iwb_rf_we_ctrl      <= 1'b0;
            o_iwb_rf_wb_src_ctrl  <= '0;
            o_iwb_sx_data         <= '0;
            o_iwb_pc_plus_4       <= '0;
            o_iwb_bu_next_dest_jb <= '0;
            o_iwb_dst             <= '0;
        end else if (o_stall) begin
            // bubble: only the write enable and the pulse matter downstream
            o_iwb_rf_we_ctrl <= 1'b0;
            o_misaligned     <= 1'b0;
        end else begin
            o_misaligned          <= illegal;
            o_iwb_load_data       <= load_data;
            o_iwb_alu_out         <= i_im_alu_out;
            o_iwb_rf_we_ctrl      <= i_im_rf_we_ctrl & ~illegal;
            o_iwb_rf_wb_src_ctrl  <= i_im_rf_wb_src_ctrl;
            o_iwb_sx_data         <= i_im_sx_data;
            o_iwb_pc_plus_4       <= i_im_pc_plus_4;
            o_iwb_bu_next_dest_jb <= i_im_bu_next_dest_jb;
            o_iwb_dst             <= i_im_dst;
        end
    end

endmodule

// File: tb/tb_im_stage.sv
module tb_im_stage;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [31:0] i_im_alu_out, i_im_write_data;
    logic        i_im_mem_we, i_im_mem_re;
    logic [2:0]  i_im_mem_size;
    logic        i_im_rf_we_ctrl;
    logic [2:0]  i_im_rf_wb_src_ctrl;
    logic [31:0] i_im_sx_data, i_im_pc_plus_4, i_im_bu_next_dest_jb;
    logic [4:0]  i_im_dst;
    logic        o_dm_req, o_dm_we;
    logic [31:0] o_dm_addr, o_dm_wdata;
    logic [3:0]  o_dm_be;
    logic [31:0] i_dm_rdata;
    logic        i_dm_ready;
    logic        o_stall;
    logic [31:0] o_m_alu_out;
    logic [4:0]  o_m_dst;
    logic        o_m_rf_we, o_misaligned;
    logic [31:0] o_iwb_load_data, o_iwb_alu_out;
    logic        o_iwb_rf_we_ctrl;
    logic [2:0]  o_iwb_rf_wb_src_ctrl;
    logic [31:0] o_iwb_sx_data, o_iwb_pc_plus_4, o_iwb_bu_next_dest_jb;
    logic [4:0]  o_iwb_dst;

    int n_tests = 0;
    int n_fail  = 0;

    im_stage dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_im_alu_out(i_im_alu_out), .i_im_write_data(i_im_write_data),
        .i_im_mem_we(i_im_mem_we), .i_im_mem_re(i_im_mem_re),
        .i_im_mem_size(i_im_mem_size), .i_im_rf_we_ctrl(i_im_rf_we_ctrl),
        .i_im_rf_wb_src_ctrl(i_im_rf_wb_src_ctrl), .i_im_sx_data(i_im_sx_data),
        .i_im_pc_plus_4(i_im_pc_plus_4), .i_im_bu_next_dest_jb(i_im_bu_next_dest_jb),
        .i_im_dst(i_im_dst),
        .o_dm_req(o_dm_req), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr),
        .o_dm_wdata(o_dm_wdata), .o_dm_be(o_dm_be),
        .i_dm_rdata(i_dm_rdata), .i_dm_ready(i_dm_ready),
        .o_stall(o_stall),
        .o_m_alu_out(o_m_alu_out), .o_m_dst(o_m_dst), .o_m_rf_we(o_m_rf_we),
        .o_misaligned(o_misaligned),
        .o_iwb_load_data(o_iwb_load_data), .o_iwb_alu_out(o_iwb_alu_out),
        .o_iwb_rf_we_ctrl(o_iwb_rf_we_ctrl), .o_iwb_rf_wb_src_ctrl(o_iwb_rf_wb_src_ctrl),
        .o_iwb_sx_data(o_iwb_sx_data), .o_iwb_pc_plus_4(o_iwb_pc_plus_4),
        .o_iwb_bu_next_dest_jb(o_iwb_bu_next_dest_jb), .o_iwb_dst(o_iwb_dst)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_legal(input bit we, input bit re, input int sz, input int a);
        bit ok;
        if (we && re) return 0;
        if (we) ok = (sz == 0 || sz == 1 || sz == 2);
        else    ok = (sz == 0 || sz == 1 || sz == 2 || sz == 4 || sz == 5);
        if (!ok) return 0;
        if ((sz == 1 || sz == 5) && (a % 2) != 0) return 0;
        if (sz == 2 && a != 0) return 0;
        return 1;
    endfunction

    function automatic logic [3:0] m_be(input int sz, input int a);
        if (sz == 0 || sz == 4) return 4'(1 << a);
        if (sz == 1 || sz == 5) return (a >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
        if (sz == 0) return (d & 32'hFF) * 32'h01010101;
        if (sz == 1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int sz, input int a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * a);
        case (sz)
            0: return ((v & 32'hFF) >= 128) ? (v & 32'hFF) + 32'hFFFFFF00 : (v & 32'hFF);
            1: return ((v & 32'hFFFF) >= 32768) ? (v & 32'hFFFF) + 32'hFFFF0000 : (v & 32'hFFFF);
            4: return v & 32'hFF;
            5: return v & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    // One instruction through IM; called at posedge+1. n = wait cycles.
    task automatic run_op(input string nm, input bit we, input bit re, input int sz,
                          input logic [31:0] addr, input logic [31:0] data, input int n,
                          input logic [31:0] rdata, input bit rfwe, input logic [4:0] dst);
        bit          lg, iss;
        int          a, stalls;
        logic [31:0] sx, pc, bu;
        logic [2:0]  src;
        a   = int'(addr & 3);
        lg  = m_legal(we, re, sz, a);
        iss = (we || re) && lg;
        sx  = $urandom; pc = $urandom; bu = $urandom; src = 3'($urandom_range(0, 7));
        i_im_alu_out = addr; i_im_write_data = data;
        i_im_mem_we = we; i_im_mem_re = re; i_im_mem_size = 3'(sz);
        i_im_rf_we_ctrl = rfwe; i_im_rf_wb_src_ctrl = src;
        i_im_sx_data = sx; i_im_pc_plus_4 = pc; i_im_bu_next_dest_jb = bu; i_im_dst = dst;
        i_dm_rdata = rdata;
        i_dm_ready = iss ? (n == 0) : 1'($urandom_range(0, 1));
        #1;
        chk({nm, ".req"}, 32'(o_dm_req), 32'(iss));
        chk({nm, ".m_alu"}, o_m_alu_out, addr);
        chk({nm, ".m_dst"}, 32'(o_m_dst), 32'(dst));
        chk({nm, ".m_rfwe"}, 32'(o_m_rf_we), 32'(rfwe));
        if (iss) begin
            chk({nm, ".addr"}, o_dm_addr, addr & 32'hFFFFFFFC);
            chk({nm, ".be"}, 32'(o_dm_be), 32'(m_be(sz, a)));
            chk({nm, ".we"}, 32'(o_dm_we), 32'(we));
            if (we) chk({nm, ".wdata"}, o_dm_wdata, m_wdata(sz, data));
        end
        stalls = int'(o_stall);
        if (iss) begin
            for (int k = 0; k < n; k++) begin
                @(posedge i_clk); #1;
                chk({nm, ".bubble"}, 32'(o_iwb_rf_we_ctrl), 32'd0);
                if (k == n - 1) i_dm_ready = 1'b1;
                #1;
                chk({nm, ".req_held"}, 32'(o_dm_req), 32'd1);
                chk({nm, ".addr_held"}, o_dm_addr, addr & 32'hFFFFFFFC);
                chk({nm, ".be_held"}, 32'(o_dm_be), 32'(m_be(sz, a)));
                if (we) chk({nm, ".wdata_held"}, o_dm_wdata, m_wdata(sz, data));
                stalls += int'(o_stall);
            end
        end
        chk({nm, ".stall_cycles"}, 32'(stalls), iss ? 32'(n) : 32'd0);
        @(posedge i_clk); #1;
        chk({nm, ".wb_rfwe"}, 32'(o_iwb_rf_we_ctrl), 32'(rfwe && !((we || re) && !lg)));
        chk({nm, ".misaligned"}, 32'(o_misaligned), 32'((we || re) && !lg));
        chk({nm, ".wb_load"}, o_iwb_load_data, (re && iss) ? m_load(sz, a, rdata) : 32'd0);
        chk({nm, ".wb_alu"}, o_iwb_alu_out, addr);
        chk({nm, ".wb_dst"}, 32'(o_iwb_dst), 32'(dst));
        chk({nm, ".wb_src"}, 32'(o_iwb_rf_wb_src_ctrl), 32'(src));
        chk({nm, ".wb_sx"}, o_iwb_sx_data, sx);
        chk({nm, ".wb_pc"}, o_iwb_pc_plus_4, pc);
        chk({nm, ".wb_bu"}, o_iwb_bu_next_dest_jb, bu);
    endtask

    initial begin
        int sel;
        i_rstn = 1'b0;
        i_im_alu_out = 32'h100; i_im_write_data = '0;
        i_im_mem_we = 1'b0; i_im_mem_re = 1'b1; i_im_mem_size = 3'b010;
        i_im_rf_we_ctrl = 1'b0; i_im_rf_wb_src_ctrl = '0;
        i_im_sx_data = '0; i_im_pc_plus_4 = '0; i_im_bu_next_dest_jb = '0; i_im_dst = '0;
        i_dm_rdata = '0; i_dm_ready = 1'b0;
        #13;
        chk("rst.req", 32'(o_dm_req), 32'd0);
        chk("rst.stall", 32'(o_stall), 32'd0);
        chk("rst.wb_rfwe", 32'(o_iwb_rf_we_ctrl), 32'd0);
        chk("rst.wb_load", o_iwb_load_data, 32'd0);
        chk("rst.misaligned", 32'(o_misaligned), 32'd0);
        i_im_mem_re = 1'b0;
        #1 i_rstn = 1'b1;
        @(posedge i_clk); #1;

        run_op("sw",  1, 0, 2, 32'h100, 32'hDEADBEEF, 0, 32'h0, 0, 5'd3);
        run_op("lb",  0, 1, 0, 32'h103, 32'h0,        3, 32'h80112233, 1, 5'd7);
        run_op("lbu", 0, 1, 4, 32'h103, 32'h0,        2, 32'h80112233, 1, 5'd8);
        run_op("sh",  1, 0, 1, 32'h102, 32'h1234,     0, 32'h0, 0, 5'd0);
        run_op("lh_mis", 0, 1, 1, 32'h101, 32'h0,     0, 32'hCAFEF00D, 1, 5'd9);
        run_op("lw0", 0, 1, 2, 32'h10,  32'h0,        0, 32'h11223344, 1, 5'd10);
        run_op("lw1", 0, 1, 2, 32'h14,  32'h0,        0, 32'h55667788, 1, 5'd11);
        run_op("lhu", 0, 1, 5, 32'h22,  32'h0,        1, 32'h9ABC0000, 1, 5'd12);
        run_op("sw_mis", 1, 0, 2, 32'h42, 32'h1,      0, 32'h0, 1, 5'd13);
        run_op("weRe", 1, 1, 2, 32'h40, 32'h1,        0, 32'h0, 1, 5'd14);
        for (int i = 0; i < 3; i++)
            run_op("add", 0, 0, 0, $urandom, 32'h0, 0, $urandom, 1, 5'd15);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            run_op("rnd", sel < 4, (sel >= 4 && sel < 8) || sel == 9,
                   $urandom_range(0, 7), $urandom, $urandom,
                   $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)));
        end

        // reset while waiting
        i_im_alu_out = 32'h103; i_im_mem_we = 1'b0; i_im_mem_re = 1'b1;
        i_im_mem_size = 3'b000; i_im_rf_we_ctrl = 1'b1; i_im_dst = 5'd5;
        i_dm_ready = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("rstw.pre_req", 32'(o_dm_req), 32'd1);
        i_rstn = 1'b0;
        #1;
        chk("rstw.req", 32'(o_dm_req), 32'd0);
        chk("rstw.stall", 32'(o_stall), 32'd0);
        chk("rstw.wb_dst", 32'(o_iwb_dst), 32'd0);
        chk("rstw.wb_alu", o_iwb_alu_out, 32'd0);
        chk("rstw.wb_pc", o_iwb_pc_plus_4, 32'd0);
        i_im_mem_re = 1'b0;
        #1 i_rstn = 1'b1;
        @(posedge i_clk); #1;
        chk("rstw.idle_req", 32'(o_dm_req), 32'd0);
        run_op("lw_after_rst", 0, 1, 2, 32'h10, 32'h0, 0, 32'hA5A5_5A5A, 1, 5'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/im_stage.md
# im_stage

Memory-access stage of the RV32I five-stage pipeline, between execute and writeback. It issues loads and stores to the data-memory port and handles byte/half/word alignment and sign extension. It stalls upstream stages while an access waits for memory, and registers results into the memory→writeback pipeline register. It also drives the execute-stage forwarding path.

## Interface
- `WIDTH`, 32, datapath width.
- `I_ADD_SIZE`, 32, PC width.
- `RF_ADD_SIZE`, 5, register-file address width.

Ports:
- `i_clk` in 1, sole clock, rising edge.
- `i_rstn` in 1, asynchronous active-low reset.
- `i_im_alu_out` in WIDTH, effective address or ALU result.
- `i_im_write_data` in WIDTH, store data (forwarded rs2).
- `i_im_mem_we` in 1, store.
- `i_im_mem_re` in 1, load.
- `i_im_mem_size` in 3, funct3 of the load/store.
- `i_im_rf_we_ctrl` in 1, pipeline control.
- `i_im_rf_wb_src_ctrl` in 3, pipeline control.
- `i_im_sx_data` in WIDTH, pipeline data.
- `i_im_pc_plus_4` in I_ADD_SIZE, pipeline data.
- `i_im_bu_next_dest_jb` in WIDTH, pipeline data.
- `i_im_dst` in RF_ADD_SIZE, destination register.
- `o_dm_req` out 1, memory request.
- `o_dm_we` out 1, write strobe.
- `o_dm_addr` out WIDTH, word-aligned address (`{alu_out[31:2],2'b00}`).
- `o_dm_wdata` out WIDTH, lane-replicated store data.
- `o_dm_be` out 4, byte enables.
- `i_dm_rdata` in WIDTH, read word, valid with ready.
- `i_dm_ready` in 1, access complete this cycle.
- `o_stall` out 1, freeze PC/IF/ID/IE registers.
- `o_m_alu_out` out WIDTH, equals `i_im_alu_out` (forwarding source).
- `o_m_dst` out RF_ADD_SIZE, for the hazard unit.
- `o_m_rf_we` out 1, for the hazard unit.
- `o_misaligned` out 1, registered one-cycle pulse on an illegal or misaligned access.
- `o_iwb_load_data` out WIDTH, registered to writeback.
- `o_iwb_alu_out` out WIDTH, registered to writeback.
- `o_iwb_rf_we_ctrl` out 1, registered to writeback.
- `o_iwb_rf_wb_src_ctrl` out 3, registered to writeback.
- `o_iwb_sx_data` out WIDTH, registered to writeback.
- `o_iwb_pc_plus_4` out I_ADD_SIZE, registered to writeback.
- `o_iwb_bu_next_dest_jb` out WIDTH, registered to writeback.
- `o_iwb_dst` out RF_ADD_SIZE, registered to writeback.

## Operation
- `access = i_im_mem_we | i_im_mem_re`. `a = i_im_alu_out[1:0]`.
- Legal stores: SB 000, SH 001, SW 010. Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- Illegal when any of:
  - the size code is outside the legal set;
  - a halfword access has `a[0]=1`;
  - a word access has `a≠0`;
  - `re` and `we` are both high.
- Illegal access: `o_dm_req=0`, no stall. The register loads normally with `o_iwb_rf_we_ctrl=0` and `o_misaligned=1` for one cycle.
- Store lanes:
  - SB: `be=4'b0001<<a`, wdata = byte ×4.
  - SH: `be = a[1] ? 1100 : 0011`, wdata = half ×2.
  - SW: `be=1111`.
- Loads: `be` computed the same way, `o_dm_we=0`. The lane is selected by `a`. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states: IDLE, WAIT.
  - IDLE: legal access drives `o_dm_req=1`. With `i_dm_ready=1`, the access completes in 0 wait states. Otherwise go to WAIT.
  - WAIT: `o_dm_req` and the address/data/be/we outputs are held (upstream is frozen, so inputs are stable). On `i_dm_ready=1`, return to IDLE.
- `o_stall = o_dm_req & ~i_dm_ready` (combinational).
- Pipeline register on each edge:
  - Not stalled: captures the inputs, plus `o_iwb_load_data` = extracted load (0 for non-loads).
  - Stalled: inserts a bubble (`o_iwb_rf_we_ctrl=0`; other fields don't-care, hold).
- `i_dm_ready` while `o_dm_req=0` is ignored.

## Timing
- Reset (async): state IDLE; every registered output is 0. `o_dm_req=0` and `o_stall=0` immediately.
- Reset asserted in WAIT abandons the access. Memory must tolerate the request dropping.
- Latency: one cycle from the instruction at IM inputs to the WB register with 0 waits; N+1 cycles with N wait cycles.
- `o_stall` is high for exactly N cycles.
- Non-memory instructions never stall and pass through in one cycle.
- `o_m_*` are combinational from the current IM inputs.

## Test plan
- SW to 0x100 (data 0xDEADBEEF), ready same cycle: req=1, we=1, be=1111, addr=0x100, stall=0; the next cycle's WB has rf_we=0 if the input had it 0.
- LB from 0x103 with rdata 0x80112233, ready after 3 cycles: stall high 3 cycles, req/addr=0x100 held; WB load_data=0xFFFFFF80, bubbles during the stall. LBU gives 0x00000080.
- SH 0x1234 to 0x102: be=1100, wdata=0x12341234. LH from 0x101: no req, `o_misaligned` pulses, WB rf_we=0.
- Back-to-back LW 0x10, 0x14 with immediate ready: two consecutive WB loads, no stall. ADD (no access) with dm_ready toggling: no req, no stall.
- Assert `i_rstn` low during WAIT: req/stall drop asynchronously, all outputs 0. After release, a fresh LW completes normally.
